// File: rtl/rf_pkg.sv
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared defaults, constants and scanner state type for the
//           rf_bank_dbg register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int REG_ZERO       = 0;

  typedef enum logic [0:0] {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_dbg_scanner.sv
// ============================================================================
// Module  : rf_dbg_scanner
// Brief   : Debug index scanner: prescaler, wrapping index counter and a
//           one-cycle tick on every index step.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_dbg_scanner
  import rf_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int SCAN_DIV = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_mode,
  input  logic              dbg_hold,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic              dbg_tick
);

  scan_state_t         r_state;
  scan_state_t         w_state_nxt;
  logic [SCAN_DIV-1:0] r_presc;
  logic [SCAN_DIV-1:0] w_presc_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic                r_tick;
  logic                w_tick_nxt;
  logic                w_presc_wrap;

  assign w_presc_wrap = (r_presc == {SCAN_DIV{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCAN_IDLE;
      r_presc <= '0;
      r_idx   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_idx   <= w_idx_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Counters are always zero in IDLE, so a step taken on the entry edge
  // starts from index 0 / prescaler 0.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_idx_nxt   = r_idx;
    w_tick_nxt  = 1'b0;
    case (r_state)
      SCAN_IDLE: begin
        w_presc_nxt = '0;
        w_idx_nxt   = '0;
        if (dbg_mode) begin
          w_state_nxt = SCAN_RUN;
          if (!dbg_hold) begin
            w_presc_nxt = r_presc + 1'b1;
            if (w_presc_wrap) begin
              w_idx_nxt  = r_idx + 1'b1;
              w_tick_nxt = 1'b1;
            end
          end
        end
      end
      SCAN_RUN: begin
        if (!dbg_mode) begin
          w_state_nxt = SCAN_IDLE;
          w_presc_nxt = '0;
          w_idx_nxt   = '0;
        end else if (!dbg_hold) begin
          w_presc_nxt = r_presc + 1'b1;
          if (w_presc_wrap) begin
            w_idx_nxt  = r_idx + 1'b1;
            w_tick_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = SCAN_IDLE;
        w_presc_nxt = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign dbg_idx  = r_idx;
  assign dbg_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/rf_bank_dbg.sv
// ============================================================================
// Module  : rf_bank_dbg
// Brief   : 2R/1W register file (x0 hardwired to zero) with a debug scanner
//           for the 7-segment display. Optional macro RF_BYPASS_EN enables
//           write-first forwarding on all read ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_bank_dbg
  import rf_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int SCAN_DIV   = 24,
  parameter int INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dbg_mode,
  input  logic              dbg_hold,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_tick,
  output logic              wr_drop
);

  localparam int               c_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_rf [c_DEPTH];
  logic              r_wr_drop;
  logic              w_wr_ok;

  assign w_wr_ok = we && !dbg_mode && (waddr != c_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_rf[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
      end
      r_wr_drop <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_rf[waddr] <= wdata;
      end
      r_wr_drop <= we && (dbg_mode || (waddr == c_ZERO));
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    if (addr == c_ZERO) begin
      v = '0;
    end else begin
      v = r_rf[addr];
`ifdef RF_BYPASS_EN
      if (w_wr_ok && (addr == waddr)) begin
        v = wdata;
      end
`endif
    end
    return v;
  endfunction

  assign rdata1   = rd_port(raddr1);
  assign rdata2   = rd_port(raddr2);
  assign dbg_data = rd_port(dbg_idx);
  assign wr_drop  = r_wr_drop;

  rf_dbg_scanner #(
    .ADDR_W  (ADDR_W),
    .SCAN_DIV(SCAN_DIV)
  ) u_scanner (
    .clk     (clk),
    .rst     (rst),
    .dbg_mode(dbg_mode),
    .dbg_hold(dbg_hold),
    .dbg_idx (dbg_idx),
    .dbg_tick(dbg_tick)
  );

endmodule

`default_nettype wire

// File: tb/tb_rf_bank_dbg.sv
// ============================================================================
// Module  : tb_rf_bank_dbg
// Brief   : Directed self-checking bench for rf_bank_dbg (SCAN_DIV=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_bank_dbg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              dbg_mode;
  logic              dbg_hold;
  logic [ADDR_W-1:0] dbg_idx;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_tick;
  logic              wr_drop;

  int n_cmp  = 0;
  int n_miss = 0;

  rf_bank_dbg #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .SCAN_DIV  (2),
    .INIT_INDEX(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .rdata1  (rdata1),
    .raddr2  (raddr2),
    .rdata2  (rdata2),
    .dbg_mode(dbg_mode),
    .dbg_hold(dbg_hold),
    .dbg_idx (dbg_idx),
    .dbg_data(dbg_data),
    .dbg_tick(dbg_tick),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected register contents after the writes of sections 2 and 3.
  function automatic logic [31:0] exp_rf(input int idx);
    if (idx == 0) return 32'h0;
    if (idx == 3) return 32'h0000AAAA;
    if (idx == 5) return 32'hDEADBEEF;
    return 32'(idx);
  endfunction

  initial begin
    int k;
    int e_idx;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; dbg_mode = 1'b0; dbg_hold = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rst_wr_drop", 32'(wr_drop), 32'd0);
    chk("rst_dbg_idx", 32'(dbg_idx), 32'd0);
    chk("rst_dbg_tick", 32'(dbg_tick), 32'd0);

    // 1. reset contents
    raddr1 = 5'd7; raddr2 = 5'd31; #1;
    chk("rd1_r7", rdata1, 32'd7);
    chk("rd2_r31", rdata2, 32'd31);
    raddr1 = 5'd0; #1;
    chk("rd1_r0", rdata1, 32'd0);

    // 2. write and x0 protection
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; raddr1 = 5'd5; #1;
    chk("wr_r5", rdata1, 32'hDEADBEEF);
    chk("wr_r5_nodrop", 32'(wr_drop), 32'd0);
    we = 1'b1; waddr = 5'd0; wdata = 32'h1;
    step();
    we = 1'b0; raddr1 = 5'd0; #1;
    chk("x0_read", rdata1, 32'd0);
    chk("x0_wr_drop", 32'(wr_drop), 32'd1);
    step();
    chk("x0_wr_drop_clr", 32'(wr_drop), 32'd0);

    // 3. debug lockout
    dbg_mode = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h0000AAAA;
    step();
    we = 1'b0; dbg_mode = 1'b0; raddr1 = 5'd3; #1;
    chk("dbg_lock_r3", rdata1, 32'd3);
    chk("dbg_lock_drop", 32'(wr_drop), 32'd1);
    we = 1'b1;
    step();
    we = 1'b0; #1;
    chk("dbg_off_r3", rdata1, 32'h0000AAAA);
    chk("dbg_off_drop", 32'(wr_drop), 32'd0);
    chk("idle_idx", 32'(dbg_idx), 32'd0);

    // 4. scanner: one step every 4 edges, wraps after 128
    dbg_mode = 1'b1;
    for (k = 1; k <= 128; k++) begin
      step();
      e_idx = (k / 4) % 32;
      chk($sformatf("scan_idx_%0d", k), 32'(dbg_idx), 32'(e_idx));
      chk($sformatf("scan_tick_%0d", k), 32'(dbg_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("scan_data_%0d", k), dbg_data, exp_rf(e_idx));
    end
    chk("scan_wrap", 32'(dbg_idx), 32'd0);
    for (k = 129; k <= 134; k++) step();
    chk("pre_hold_idx", 32'(dbg_idx), 32'd1);
    dbg_hold = 1'b1;
    for (k = 0; k < 10; k++) begin
      step();
      chk($sformatf("hold_idx_%0d", k), 32'(dbg_idx), 32'd1);
      chk($sformatf("hold_tick_%0d", k), 32'(dbg_tick), 32'd0);
    end
    dbg_hold = 1'b0;
    step();
    chk("unhold_idx_a", 32'(dbg_idx), 32'd1);
    chk("unhold_tick_a", 32'(dbg_tick), 32'd0);
    step();
    chk("unhold_idx_b", 32'(dbg_idx), 32'd2);
    chk("unhold_tick_b", 32'(dbg_tick), 32'd1);
    chk("unhold_data_b", dbg_data, 32'd2);

    // 5. reset mid-scan (edge that would step to 10) and mid-write
    for (k = 0; k < 28; k++) step();
    chk("mid_idx9", 32'(dbg_idx), 32'd9);
    chk("mid_data9", dbg_data, 32'd9);
    step(); step(); step();
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h0000FFFF;
    step();
    chk("rst_scan_idx", 32'(dbg_idx), 32'd0);
    chk("rst_scan_tick", 32'(dbg_tick), 32'd0);
    chk("rst_scan_drop", 32'(wr_drop), 32'd0);
    dbg_mode = 1'b0;
    step();
    rst = 1'b0; we = 1'b0; raddr1 = 5'd4; raddr2 = 5'd5; #1;
    chk("rst_wr_r4", rdata1, 32'd4);
    chk("rst_r5", rdata2, 32'd5);

    // 6. simultaneous read/write
    we = 1'b1; waddr = 5'd6; wdata = 32'h55; raddr1 = 5'd6; #1;
`ifdef RF_BYPASS_EN
    chk("rw_same_cycle", rdata1, 32'h55);
`else
    chk("rw_same_cycle", rdata1, 32'd6);
`endif
    step();
    we = 1'b0; #1;
    chk("rw_next_cycle", rdata1, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
